// File: rtl/avr_irq_ctrl.sv
// avr_irq_ctrl: latched/masked/prioritised IRQ front end for avr_core.
// Optional round-robin priority: define AVR_IRQ_ROTATE_EN.
module avr_irq_ctrl #(
  parameter int N_IRQ = 4,
  parameter int VW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_lines,
  input  logic             io_sel,
  input  logic             io_re,
  input  logic             io_we,
  input  logic [1:0]       io_a,
  input  logic [7:0]       io_din,
  output logic [7:0]       io_dout,
  output logic             iflag,
  output logic [VW-1:0]    ivect,
  input  logic             irq_ack
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  state_t state, state_n;

  logic [N_IRQ-1:0] ie, edg, edg_n;
  logic [N_IRQ-1:0] pend_q, prev;
  logic [N_IRQ-1:0] pend, cand;
  logic [N_IRQ-1:0] set_e, clr;
  logic [VW-1:0]    vect, vect_n, win, ptr;
  logic [7:0]       stat;
  logic             wr, any, ack_take;

  assign wr       = io_sel & io_we;
  assign set_e    = edg & irq_lines & ~prev;
  assign pend     = (edg & pend_q) | (~edg & irq_lines);
  assign cand     = pend & ie;
  assign any      = |cand;
  assign ack_take = (state == REQ) & irq_ack;
  assign edg_n    = (wr && io_a == 2'd1) ?
                    io_din[N_IRQ-1:0] : edg;

  always_comb begin
    clr = '0;
    if (wr && io_a == 2'd2)
      clr = io_din[N_IRQ-1:0];
    if (ack_take)
      clr[vect] = 1'b1;
  end

`ifdef AVR_IRQ_ROTATE_EN
  logic found;
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (!found && cand[(int'(ptr) + i) % N_IRQ]) begin
        win   = VW'((int'(ptr) + i) % N_IRQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (ack_take)
      ptr <= VW'((int'(vect) + 1) % N_IRQ);
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (cand[i])
        win = VW'(i);
  end

  assign ptr = '0;
`endif

  always_comb begin
    state_n = state;
    vect_n  = vect;
    unique case (state)
      IDLE: begin
        if (any) begin
          vect_n  = win;
          state_n = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_n = GAP;
        end else if (!cand[vect]) begin
          state_n = IDLE;
          vect_n  = '0;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // pend_q is masked by the next EDGE value so a 1->0 change drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      vect   <= '0;
      ie     <= '0;
      edg    <= '0;
      pend_q <= '0;
      prev   <= '0;
    end else begin
      state  <= state_n;
      vect   <= vect_n;
      prev   <= irq_lines;
      edg    <= edg_n;
      pend_q <= ((pend_q & ~clr) | set_e) & edg_n;
      if (wr && io_a == 2'd0)
        ie <= io_din[N_IRQ-1:0];
    end
  end

  assign iflag = (state == REQ);
  assign ivect = vect;

  always_comb begin
    stat         = '0;
    stat[7]      = (state != IDLE);
    stat[6:4]    = 3'(ptr);
    stat[VW-1:0] = vect;
  end

  always_comb begin
    io_dout = '0;
    if (io_sel && io_re && !rst) begin
      unique case (io_a)
        2'd0: io_dout = 8'(ie);
        2'd1: io_dout = 8'(edg);
        2'd2: io_dout = 8'(pend);
        2'd3: io_dout = stat;
        default: io_dout = '0;
      endcase
    end
  end

endmodule
